// File: rtl/hw2_frame_acc.sv
// hw2_frame_acc: saturating frame accumulator behind the hw2 add/sub-multiply
// stage. Samples are summed into a signed clamped accumulator. A frame closes
// after FRAME_LEN samples, or earlier on flush. The finished frame is then held
// on the outputs until the downstream side takes it.
module hw2_frame_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 32,
  parameter int ACC_WIDTH  = 20,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] in_d,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out_sum,
  output logic [CNT_WIDTH-1:0]    out_cnt,
  output logic                    out_sat
);

  localparam int IW = 2*DATA_WIDTH;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [1:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sat;

  logic                 accept;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf_pos, ovf_neg;
  logic [ACC_WIDTH-1:0] acc_nx, fin_acc;
  logic [CNT_WIDTH-1:0] cnt_nx, fin_cnt;
  logic                 fin_sat;
  logic                 close;

  // Pure state decode: no path from out_ready into in_ready.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // One guard bit above the accumulator catches overflow in either direction;
  // the sample is narrower than the accumulator so the sum always fits.
  always_comb begin
    sum     = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH+1-IW){in_d[IW-1]}}, in_d};
    ovf_pos = !sum[ACC_WIDTH] &&  sum[ACC_WIDTH-1];
    ovf_neg =  sum[ACC_WIDTH] && !sum[ACC_WIDTH-1];
    acc_nx  = ovf_pos ? ACC_MAX : (ovf_neg ? ACC_MIN : sum[ACC_WIDTH-1:0]);
    cnt_nx  = cnt + 1'b1;
    // Values the frame closes with, including a sample accepted this cycle.
    fin_acc = accept ? acc_nx : acc;
    fin_cnt = accept ? cnt_nx : cnt;
    fin_sat = sat | (accept && (ovf_pos || ovf_neg));
    // Flush without a sample only closes a frame that already has samples.
    close   = (state != HOLD) &&
              ((accept && (cnt_nx == CNT_WIDTH'(FRAME_LEN) || flush)) ||
               (flush && cnt != '0));
  end

  // Frame FSM, accumulator and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else if (close) begin
      out_sum   <= fin_acc;
      out_cnt   <= fin_cnt;
      out_sat   <= fin_sat;
      out_valid <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      state     <= HOLD;
    end else if (accept) begin
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      sat       <= fin_sat;
      state     <= ACCUM;
    end else if (state == HOLD && out_ready) begin
      // Result registers keep their last values after the handshake.
      out_valid <= 1'b0;
      state     <= IDLE;
    end
  end

endmodule
